// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO switch/display/timer peripheral:
// register offsets, default window base, TSTAT bit index and the
// offset-to-register decode helper.
package mmio_pkg;

    localparam logic [15:0] DEF_BASE_ADDR = 16'hFFF0;

    localparam logic [2:0] OFS_DISP  = 3'd0;
    localparam logic [2:0] OFS_SW    = 3'd2;
    localparam logic [2:0] OFS_TLOAD = 3'd4;
    localparam logic [2:0] OFS_TSTAT = 3'd6;

    localparam int unsigned TSTAT_EXP_BIT = 0;

    typedef enum logic [1:0] {
        REG_DISP  = 2'd0,
        REG_SW    = 2'd1,
        REG_TLOAD = 2'd2,
        REG_TSTAT = 2'd3
    } reg_sel_e;

    // Byte offset within the window to register; bit 0 is a don't-care.
    function automatic reg_sel_e decode_reg(input logic [2:0] ofs);
        reg_sel_e r;
        case (ofs & 3'b110)
            OFS_DISP:  r = REG_DISP;
            OFS_SW:    r = REG_SW;
            OFS_TLOAD: r = REG_TLOAD;
            OFS_TSTAT: r = REG_TSTAT;
            default:   r = REG_DISP;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One-bit switch conditioner: 2-flop synchronizer followed by a
// debounce counter. The debounced output flips only after
// DEBOUNCE_CYCLES consecutive synchronized samples differ from it.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_db
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             db_q,    db_d;

    // Synchronizer shift and debounce counting; any agreement restarts the count.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        db_d    = db_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/mmio_timer_io.sv
// Memory-mapped I/O block: seven-segment display register, two
// debounced switches and an optional countdown timer with an
// expired flag on irq. Timer is built only when MMIO_TIMER_EN is
// defined; otherwise TLOAD/TSTAT read 0, ignore writes, irq is 0.
module mmio_timer_io
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR       = DEF_BASE_ADDR,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] draddr,
    input  logic [15:0] dwdata,
    input  logic        dwrite,
    input  logic        dread,
    output logic [15:0] drdata,
    output logic        sel,
    input  logic        io_sw0,
    input  logic        io_sw1,
    output logic [6:0]  io_display,
    output logic        irq
);

    logic       wr_en;
    reg_sel_e   rsel;
    logic [6:0] disp_q, disp_d;
    logic       sw0_db, sw1_db;
    logic [15:0] count_rd;
    logic        expired_rd;
    logic [15:0] tstat_rd;

    assign sel   = (draddr[15:3] == BASE_ADDR[15:3]);
    assign wr_en = dwrite && sel;
    assign rsel  = decode_reg(draddr[2:0]);

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
        .clock  (clock),
        .reset  (reset),
        .sw_raw (io_sw0),
        .sw_db  (sw0_db)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
        .clock  (clock),
        .reset  (reset),
        .sw_raw (io_sw1),
        .sw_db  (sw1_db)
    );

    // Display register next value.
    always_comb begin
        disp_d = disp_q;
        if (wr_en && rsel == REG_DISP) begin
            disp_d = dwdata[6:0];
        end
    end

    // Display register.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [15:0] count_q, count_d;
    logic        expired_q, expired_d;
    logic        load, clr;

    // Countdown: a load overrides the decrement; expiry beats a clear.
    always_comb begin
        load      = wr_en && rsel == REG_TLOAD;
        clr       = wr_en && rsel == REG_TSTAT && dwdata[TSTAT_EXP_BIT];
        count_d   = count_q;
        expired_d = expired_q;
        if (load) begin
            count_d = dwdata;
        end else if (count_q != '0) begin
            count_d = count_q - 16'd1;
        end
        if (clr) begin
            expired_d = 1'b0;
        end
        if (!load && count_q == 16'd1) begin
            expired_d = 1'b1;
        end
    end

    // Timer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign count_rd   = count_q;
    assign expired_rd = expired_q;
`else
    logic unused_wdata;

    assign unused_wdata = ^dwdata[15:7];
    assign count_rd     = '0;
    assign expired_rd   = 1'b0;
`endif

    // TSTAT read image.
    always_comb begin
        tstat_rd                = '0;
        tstat_rd[TSTAT_EXP_BIT] = expired_rd;
    end

    // Combinational read mux; zero unless a selected read.
    always_comb begin
        drdata = '0;
        if (dread && sel) begin
            case (rsel)
                REG_DISP:  drdata = {9'b0, disp_q};
                REG_SW:    drdata = {14'b0, sw1_db, sw0_db};
                REG_TLOAD: drdata = count_rd;
                REG_TSTAT: drdata = tstat_rd;
                default:   drdata = '0;
            endcase
        end
    end

    assign io_display = disp_q;
    assign irq        = expired_rd;

endmodule

// File: tb/tb_mmio_timer_io.sv
// Self-checking bench for mmio_timer_io: directed literal checks plus a
// randomized phase compared every cycle against a behavioural model.
// Timer expectations follow MMIO_TIMER_EN.
module tb_mmio_timer_io;

    localparam logic [15:0] BASE = 16'hFFF0;
    localparam int unsigned DB   = 4;
`ifdef MMIO_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] draddr, dwdata, drdata;
    logic        dwrite, dread, sel;
    logic        io_sw0, io_sw1;
    logic [6:0]  io_display;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state
    logic [6:0]  m_disp;
    logic [15:0] m_count;
    bit          m_exp;
    bit          m_db0, m_db1;
    bit          hist0[$];
    bit          hist1[$];

    mmio_timer_io #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB)) dut (
        .clock      (clock),
        .reset      (reset),
        .draddr     (draddr),
        .dwdata     (dwdata),
        .dwrite     (dwrite),
        .dread      (dread),
        .drdata     (drdata),
        .sel        (sel),
        .io_sw0     (io_sw0),
        .io_sw1     (io_sw1),
        .io_display (io_display),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (a >= BASE) && (int'(a) <= int'(BASE) + 7);
    endfunction

    // Debounced value after this edge: flips only if the DB most recent
    // values the debouncer has seen (raw samples 2..DB+1 edges old) all differ.
    function automatic bit settle(input bit h[$], input bit db);
        for (int k = 2; k < DB + 2; k++) begin
            if (h[k] == db) return db;
        end
        return !db;
    endfunction

    function automatic logic [15:0] exp_rd();
        int o;
        if (!(dread && in_win(draddr))) return 16'h0000;
        o = (int'(draddr) - int'(BASE)) / 2;
        case (o)
            0:       return {9'b0, m_disp};
            1:       return {14'b0, m_db1, m_db0};
            2:       return TIMER_ON ? m_count : 16'h0000;
            default: return {15'b0, TIMER_ON & m_exp};
        endcase
    endfunction

    // Model update at each rising edge from the inputs presented
    always @(posedge clock) begin
        if (reset) begin
            m_disp  = '0;
            m_count = '0;
            m_exp   = 1'b0;
            m_db0   = 1'b0;
            m_db1   = 1'b0;
            hist0   = {};
            hist1   = {};
            for (int k = 0; k < DB + 2; k++) begin
                hist0.push_back(1'b0);
                hist1.push_back(1'b0);
            end
        end else begin
            bit we;
            bit expire_now;
            int o;
            we = dwrite && in_win(draddr);
            o  = (int'(draddr) - int'(BASE)) / 2;
            expire_now = (m_count == 16'd1) && !(we && o == 2);
            if (we && o == 0) m_disp = dwdata[6:0];
            if (we && o == 2) m_count = dwdata;
            else if (m_count != 0) m_count = m_count - 16'd1;
            if (we && o == 3 && dwdata[0]) m_exp = 1'b0;
            if (expire_now) m_exp = 1'b1;
            hist0.push_front(io_sw0);
            void'(hist0.pop_back());
            hist1.push_front(io_sw1);
            void'(hist1.pop_back());
            m_db0 = settle(hist0, m_db0);
            m_db1 = settle(hist1, m_db1);
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_drdata", drdata, exp_rd());
            check("cyc_sel", {15'b0, sel}, {15'b0, in_win(draddr)});
            check("cyc_display", {9'b0, io_display}, {9'b0, m_disp});
            check("cyc_irq", {15'b0, irq}, {15'b0, TIMER_ON & m_exp});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        draddr = a;
        dwdata = d;
        dwrite = 1'b1;
        tick();
        dwrite = 1'b0;
    endtask

    task automatic read_chk(input logic [15:0] a, input logic [15:0] exp, input string name);
        draddr = a;
        dread  = 1'b1;
        #1;
        check(name, drdata, exp);
        dread  = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        draddr = '0;
        dwdata = '0;
        dwrite = 1'b0;
        dread  = 1'b0;
        io_sw0 = 1'b0;
        io_sw1 = 1'b0;
        tick();
        cmp_en = 1'b1;

        // Reset beats a coincident write
        draddr = 16'hFFF0;
        dwdata = 16'h002A;
        dwrite = 1'b1;
        tick();
        dwrite = 1'b0;
        reset  = 1'b0;
        check("rst_display", {9'b0, io_display}, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        read_chk(16'hFFF0, 16'h0000, "rst_disp");
        read_chk(16'hFFF2, 16'h0000, "rst_sw");
        read_chk(16'hFFF4, 16'h0000, "rst_count");
        read_chk(16'hFFF6, 16'h0000, "rst_tstat");

        // Display write and readback (odd address aliases)
        bus_write(16'hFFF0, 16'h007F);
        check("disp_out", {9'b0, io_display}, 16'h007F);
        read_chk(16'hFFF0, 16'h007F, "disp_rd");
        read_chk(16'hFFF1, 16'h007F, "disp_rd_odd");

        // Write outside the window
        draddr = 16'h0010;
        dwdata = 16'h0000;
        dwrite = 1'b1;
        #1;
        check("sel_outside", {15'b0, sel}, 16'h0000);
        tick();
        dwrite = 1'b0;
        check("outside_display", {9'b0, io_display}, 16'h007F);
        read_chk(16'hFFF0, 16'h007F, "outside_disp_rd");

        // Switch 0 latency: 2 + DB edges
        io_sw0 = 1'b1;
        repeat (5) tick();
        read_chk(16'hFFF2, 16'h0000, "sw0_at5");
        tick();
        read_chk(16'hFFF2, 16'h0001, "sw0_at6");

        // Switch 1 bounce 1,0,1 then hold
        io_sw1 = 1'b1;
        tick();
        io_sw1 = 1'b0;
        tick();
        io_sw1 = 1'b1;
        repeat (5) tick();
        read_chk(16'hFFF2, 16'h0001, "sw1_at5");
        tick();
        read_chk(16'hFFF2, 16'h0003, "sw1_at6");

`ifdef MMIO_TIMER_EN
        bus_write(16'hFFF4, 16'd3);
        read_chk(16'hFFF4, 16'd3, "cnt3");
        check("irq_cnt3", {15'b0, irq}, 16'h0000);
        tick();
        read_chk(16'hFFF4, 16'd2, "cnt2");
        tick();
        read_chk(16'hFFF4, 16'd1, "cnt1");
        tick();
        read_chk(16'hFFF4, 16'd0, "cnt0");
        check("irq_expired", {15'b0, irq}, 16'h0001);
        read_chk(16'hFFF6, 16'h0001, "tstat_set");
        bus_write(16'hFFF6, 16'h0000);
        check("irq_write0", {15'b0, irq}, 16'h0001);
        bus_write(16'hFFF6, 16'h0001);
        check("irq_cleared", {15'b0, irq}, 16'h0000);

        // Clear-write in the expiry cycle: expiry wins
        bus_write(16'hFFF4, 16'd2);
        tick();
        read_chk(16'hFFF4, 16'd1, "race_cnt1");
        bus_write(16'hFFF6, 16'h0001);
        check("irq_race", {15'b0, irq}, 16'h0001);
        bus_write(16'hFFF6, 16'h0001);
        check("irq_race_clr", {15'b0, irq}, 16'h0000);

        // Loading 0 over a pending expiry stops without expiring
        bus_write(16'hFFF4, 16'd1);
        bus_write(16'hFFF4, 16'd0);
        tick();
        check("load0_irq", {15'b0, irq}, 16'h0000);

        // Reset mid-countdown
        bus_write(16'hFFF4, 16'd10);
        repeat (5) tick();
        read_chk(16'hFFF4, 16'd5, "cnt5");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_chk(16'hFFF4, 16'd0, "abort_cnt");
        repeat (12) tick();
        check("abort_irq", {15'b0, irq}, 16'h0000);
        check("abort_display", {9'b0, io_display}, 16'h0000);
`else
        bus_write(16'hFFF4, 16'd5);
        read_chk(16'hFFF4, 16'h0000, "notimer_cnt");
        bus_write(16'hFFF6, 16'h0001);
        repeat (8) tick();
        check("notimer_irq", {15'b0, irq}, 16'h0000);
        read_chk(16'hFFF4, 16'h0000, "notimer_cnt2");
`endif

        // Randomized phase, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 299) == 0);
            dwrite = ($urandom_range(0, 2) == 0);
            dread  = ($urandom_range(0, 1) == 1);
            draddr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : (BASE | 16'($urandom_range(0, 7)));
            dwdata = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12)) : 16'($urandom);
            if ($urandom_range(0, 19) == 0) io_sw0 = ~io_sw0;
            if ($urandom_range(0, 19) == 0) io_sw1 = ~io_sw1;
            tick();
        end
        reset  = 1'b0;
        dwrite = 1'b0;
        dread  = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
